ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage
Interface
REQ-001 SQUASH_DEPTH, 2, number of younger instructions killed after a redirect (1..3).
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 reset  in  1  asynchronous, active-high.
REQ-004 stall  in  1  hold EX/MEM contents and squash counter.
REQ-005 id_valid  in  1  ID/EX slot holds a real instruction.
REQ-006 id_ctrl  in  15  packed ex_ctrl_t: regwrite, result_src[1:0], memwrite, jump, jalr, branch, funct3[2:0], alu_control[3:0], alu_src.
REQ-007 id_pc  in  32  instruction PC.
REQ-008 id_pc_plus_4  in  32  PC+4.
REQ-009 id_rs1_data  in  32  register operand A.
REQ-010 id_rs2_data  in  32  register operand B.
REQ-011 id_imm  in  32  sign-extended immediate.
REQ-012 id_rs1  in  5  source register A index.
REQ-013 id_rs2  in  5  source register B index.
REQ-014 id_rd  in  5  destination index.
REQ-015 mem_fwd_rd  in  5  MEM-stage destination; 0 = nothing to forward.
REQ-016 mem_fwd_data  in  32  MEM-stage result.
REQ-017 wb_fwd_rd  in  5  WB-stage destination; 0 = nothing to forward.
REQ-018 wb_fwd_data  in  32  WB-stage result.
REQ-019 pc_src  out  1  redirect fetch this cycle (combinational).
REQ-020 pc_branch_dest  out  32  redirect target (combinational).
REQ-021 ex_mem_valid  out  1  registered valid.
REQ-022 ex_mem_ctrl  out  4  packed mem_ctrl_t: regwrite, result_src[1:0], memwrite.
REQ-023 ex_mem_alu_result  out  32  registered ALU result.
REQ-024 ex_mem_write_data  out  32  registered store data (forwarded rs2).
REQ-025 ex_mem_rd  out  5  registered destination.
REQ-026 ex_mem_pc_plus_4  out  32  registered PC+4 for jump link.
Function
REQ-027 Instruction is live when id_valid=1 and squash counter=0; live instructions reach EX/MEM one clk edge later (latency 1).
REQ-028 ALU ops by alu_control: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 PASS_B; 11-15 yield 0; shifts use B[4:0]; add/sub wrap mod 2^32.
REQ-029 Operand B = id_imm when alu_src=1, else forwarded rs2; store data always forwarded rs2.
REQ-030 Branch condition by funct3: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; 010/011 never taken.
REQ-031 pc_src = live & ~stall & (jump | (branch & taken)); target = (rs1+imm)&~1 if jalr, else id_pc+id_imm.
REQ-032 On pc_src, squash counter loads SQUASH_DEPTH at the edge; decrements each unstalled cycle to 0; squashed slots write ex_mem_valid=0 and force ex_mem_ctrl=0.
REQ-033 Redirect while counter nonzero is impossible (no live instr); stall freezes counter and all EX/MEM registers.
Reset
REQ-034 Reset clears ex_mem_valid, ex_mem_ctrl, ex_mem_rd, squash counter and all data registers to 0 immediately; pc_src is 0 whenever no live instruction.
REQ-035 Reset mid-squash abandons squash; first post-reset valid instruction is live.
Configuration
REQ-036 EX_FORWARD_EN defined: operand = mem_fwd_data if rs==mem_fwd_rd!=0, else wb_fwd_data if rs==wb_fwd_rd!=0, else register data (MEM priority); undefined: forwarding ports ignored, register data used.
Structure
REQ-037 ex_ctrl_t, mem_ctrl_t, ALU opcode and funct3 constants live in riscv_pkg; ALU is sub-module ex_alu (combinational).
Verification
REQ-038 ADD rs1=5, imm=7, alu_src=1 -> next edge ex_mem_alu_result=12, ex_mem_valid=1.
REQ-039 BEQ rs1=rs2=3, pc=0x100, imm=0x20 -> pc_src=1, dest=0x120; next 2 instrs give ex_mem_valid=0.
REQ-040 EX_FORWARD_EN, rs1=1, mem_fwd_rd=1 (data 9), wb_fwd_rd=1 (data 4), ADD imm=1 -> result 10; without macro result=rs1_data+1.
REQ-041 JALR rs1=0x203, imm=0 -> dest=0x202, ex_mem_pc_plus_4=pc+4.
REQ-042 SRA 0x80000000 by 33 -> 0xC0000000; stall held 3 cycles -> outputs unchanged; reset asserted mid-squash -> ex_mem_valid=0 at once.

---
 rtl/riscv_pkg.sv | 60 ++++++
 rtl/ex_alu.sv | 44 ++++
 rtl/ex_stage.sv | 145 ++++++++++++++
 tb/tb_ex_stage.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared types and constants for the execute stage of the pipeline.
//   ex_ctrl_t  : 15-bit control bundle carried in the ID/EX slot
//   mem_ctrl_t : 4-bit control subset forwarded into EX/MEM
//   alu_op_e   : ALU operation codes carried in ex_ctrl_t.alu_control
//   F3_*       : branch condition encodings carried in ex_ctrl_t.funct3
//   toMemCtrl  : extracts the EX/MEM control subset from an ex_ctrl_t
// ---------------------------------------------------------------------------
package riscv_pkg;

  typedef struct packed {
    logic       regwrite;
    logic [1:0] result_src;
    logic       memwrite;
    logic       jump;
    logic       jalr;
    logic       branch;
    logic [2:0] funct3;
    logic [3:0] alu_control;
    logic       alu_src;
  } ex_ctrl_t;

  typedef struct packed {
    logic       regwrite;
    logic [1:0] result_src;
    logic       memwrite;
  } mem_ctrl_t;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_AND    = 4'd2,
    ALU_OR     = 4'd3,
    ALU_XOR    = 4'd4,
    ALU_SLT    = 4'd5,
    ALU_SLTU   = 4'd6,
    ALU_SLL    = 4'd7,
    ALU_SRL    = 4'd8,
    ALU_SRA    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Only the fields the memory and writeback stages consume survive past EX.
  function automatic mem_ctrl_t toMemCtrl(input ex_ctrl_t ctrl);
    mem_ctrl_t m;
    m.regwrite   = ctrl.regwrite;
    m.result_src = ctrl.result_src;
    m.memwrite   = ctrl.memwrite;
    return m;
  endfunction

endpackage

// File: rtl/ex_alu.sv
// ---------------------------------------------------------------------------
// ex_alu
// Purely combinational 32-bit ALU used by the execute stage.
//   i_a      : operand A
//   i_b      : operand B (shift amount taken from i_b[4:0])
//   i_op     : operation code (riscv_pkg::alu_op_e values)
//   o_result : result; unassigned opcodes 11..15 give zero
// ---------------------------------------------------------------------------
module ex_alu
  import riscv_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [3:0]  i_op,
  output logic [31:0] o_result
);

  logic [4:0] w_shamt;

  assign w_shamt = i_b[4:0];

  // One result per opcode. Add and subtract simply wrap at 32 bits, and the
  // two compare ops produce a 0/1 value in bit 0. Anything outside the
  // defined opcode range falls through to zero so garbage control never
  // leaks a stale value into EX/MEM.
  always_comb begin
    o_result = 32'd0;
    case (i_op)
      ALU_ADD:    o_result = i_a + i_b;
      ALU_SUB:    o_result = i_a - i_b;
      ALU_AND:    o_result = i_a & i_b;
      ALU_OR:     o_result = i_a | i_b;
      ALU_XOR:    o_result = i_a ^ i_b;
      ALU_SLT:    o_result = {31'd0, $signed(i_a) < $signed(i_b)};
      ALU_SLTU:   o_result = {31'd0, i_a < i_b};
      ALU_SLL:    o_result = i_a << w_shamt;
      ALU_SRL:    o_result = i_a >> w_shamt;
      ALU_SRA:    o_result = $unsigned($signed(i_a) >>> w_shamt);
      ALU_PASS_B: o_result = i_b;
      default:    o_result = 32'd0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage
// Execute stage: operand forwarding, ALU, branch/jump resolution, post-
// redirect squashing and the EX/MEM pipeline register.
// Optional feature macro: EX_FORWARD_EN (enables MEM/WB operand forwarding;
// when undefined the forwarding ports are ignored).
//   clk, reset        : clock (rising edge) and async active-high reset
//   stall             : freezes EX/MEM and the squash counter
//   id_valid, id_ctrl : ID/EX slot valid flag and control bundle
//   id_pc, id_pc_plus_4, id_rs1_data, id_rs2_data, id_imm : slot data
//   id_rs1, id_rs2, id_rd : register indices
//   mem_fwd_rd/data, wb_fwd_rd/data : forwarding sources (rd 0 = none)
//   pc_src, pc_branch_dest : combinational fetch redirect and its target
//   ex_mem_*          : registered EX/MEM outputs
// ---------------------------------------------------------------------------
module ex_stage
  import riscv_pkg::*;
#(
  parameter int SQUASH_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        id_valid,
  input  ex_ctrl_t    id_ctrl,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_pc_plus_4,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic [4:0]  mem_fwd_rd,
  input  logic [31:0] mem_fwd_data,
  input  logic [4:0]  wb_fwd_rd,
  input  logic [31:0] wb_fwd_data,
  output logic        pc_src,
  output logic [31:0] pc_branch_dest,
  output logic        ex_mem_valid,
  output mem_ctrl_t   ex_mem_ctrl,
  output logic [31:0] ex_mem_alu_result,
  output logic [31:0] ex_mem_write_data,
  output logic [4:0]  ex_mem_rd,
  output logic [31:0] ex_mem_pc_plus_4
);

  localparam logic [1:0] SQUASH_LOAD = 2'(SQUASH_DEPTH);

  logic [1:0]  r_squashCnt;
  logic        w_live;
  logic        w_taken;
  logic [31:0] w_rs1Fwd;
  logic [31:0] w_rs2Fwd;
  logic [31:0] w_opB;
  logic [31:0] w_aluResult;

`ifdef EX_FORWARD_EN
  // Pick the freshest copy of each source register. MEM holds a younger
  // result than WB, so it wins when both target the same register; x0 is
  // never forwarded because it is hardwired to zero.
  always_comb begin
    w_rs1Fwd = id_rs1_data;
    w_rs2Fwd = id_rs2_data;
    if (id_rs1 != 5'd0 && id_rs1 == mem_fwd_rd)
      w_rs1Fwd = mem_fwd_data;
    else if (id_rs1 != 5'd0 && id_rs1 == wb_fwd_rd)
      w_rs1Fwd = wb_fwd_data;
    if (id_rs2 != 5'd0 && id_rs2 == mem_fwd_rd)
      w_rs2Fwd = mem_fwd_data;
    else if (id_rs2 != 5'd0 && id_rs2 == wb_fwd_rd)
      w_rs2Fwd = wb_fwd_data;
  end
`else
  // Without forwarding the register file values are used as-is; the
  // forwarding inputs are folded into a sink so they stay connected.
  logic w_unusedFwd;
  assign w_rs1Fwd    = id_rs1_data;
  assign w_rs2Fwd    = id_rs2_data;
  assign w_unusedFwd = ^{id_rs1, id_rs2, mem_fwd_rd, mem_fwd_data,
                         wb_fwd_rd, wb_fwd_data};
`endif

  // A slot only counts while no redirect shadow is pending.
  assign w_live = id_valid && (r_squashCnt == 2'd0);
  assign w_opB  = id_ctrl.alu_src ? id_imm : w_rs2Fwd;

  ex_alu u_alu (
    .i_a      (w_rs1Fwd),
    .i_b      (w_opB),
    .i_op     (id_ctrl.alu_control),
    .o_result (w_aluResult)
  );

  // Branch comparator works on the forwarded register operands, never on
  // the immediate, so it is independent of alu_src. The two reserved
  // funct3 codes fall to the default and never branch.
  always_comb begin
    w_taken = 1'b0;
    case (id_ctrl.funct3)
      F3_BEQ:  w_taken = (w_rs1Fwd == w_rs2Fwd);
      F3_BNE:  w_taken = (w_rs1Fwd != w_rs2Fwd);
      F3_BLT:  w_taken = ($signed(w_rs1Fwd) <  $signed(w_rs2Fwd));
      F3_BGE:  w_taken = ($signed(w_rs1Fwd) >= $signed(w_rs2Fwd));
      F3_BLTU: w_taken = (w_rs1Fwd <  w_rs2Fwd);
      F3_BGEU: w_taken = (w_rs1Fwd >= w_rs2Fwd);
      default: w_taken = 1'b0;
    endcase
  end

  // A stalled redirect is held back so it fires exactly once, on the cycle
  // the instruction actually leaves EX. JALR clears bit 0 of its target.
  assign pc_src         = w_live && !stall &&
                          (id_ctrl.jump || (id_ctrl.branch && w_taken));
  assign pc_branch_dest = id_ctrl.jalr ? ((w_rs1Fwd + id_imm) & ~32'd1)
                                       : (id_pc + id_imm);

  // EX/MEM register and squash counter. A redirect loads the counter so the
  // next SQUASH_DEPTH slots, already fetched down the wrong path, enter
  // EX/MEM as bubbles with their control zeroed. Stall freezes everything,
  // and reset drops any squash in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_squashCnt       <= 2'd0;
      ex_mem_valid      <= 1'b0;
      ex_mem_ctrl       <= '0;
      ex_mem_alu_result <= 32'd0;
      ex_mem_write_data <= 32'd0;
      ex_mem_rd         <= 5'd0;
      ex_mem_pc_plus_4  <= 32'd0;
    end else if (!stall) begin
      if (pc_src)
        r_squashCnt <= SQUASH_LOAD;
      else if (r_squashCnt != 2'd0)
        r_squashCnt <= r_squashCnt - 2'd1;
      ex_mem_valid      <= w_live;
      ex_mem_ctrl       <= w_live ? toMemCtrl(id_ctrl) : '0;
      ex_mem_alu_result <= w_aluResult;
      ex_mem_write_data <= w_rs2Fwd;
      ex_mem_rd         <= id_rd;
      ex_mem_pc_plus_4  <= id_pc_plus_4;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_stage
// Directed testbench for ex_stage with hand-computed expected values.
// ---------------------------------------------------------------------------
module tb_ex_stage;
  import riscv_pkg::*;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        id_valid;
  ex_ctrl_t    id_ctrl;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus_4;
  logic [31:0] id_rs1_data;
  logic [31:0] id_rs2_data;
  logic [31:0] id_imm;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic [4:0]  mem_fwd_rd;
  logic [31:0] mem_fwd_data;
  logic [4:0]  wb_fwd_rd;
  logic [31:0] wb_fwd_data;
  logic        pc_src;
  logic [31:0] pc_branch_dest;
  logic        ex_mem_valid;
  mem_ctrl_t   ex_mem_ctrl;
  logic [31:0] ex_mem_alu_result;
  logic [31:0] ex_mem_write_data;
  logic [4:0]  ex_mem_rd;
  logic [31:0] ex_mem_pc_plus_4;

  int checks = 0;
  int errors = 0;

  ex_stage #(.SQUASH_DEPTH(2)) dut (
    .clk               (clk),
    .reset             (reset),
    .stall             (stall),
    .id_valid          (id_valid),
    .id_ctrl           (id_ctrl),
    .id_pc             (id_pc),
    .id_pc_plus_4      (id_pc_plus_4),
    .id_rs1_data       (id_rs1_data),
    .id_rs2_data       (id_rs2_data),
    .id_imm            (id_imm),
    .id_rs1            (id_rs1),
    .id_rs2            (id_rs2),
    .id_rd             (id_rd),
    .mem_fwd_rd        (mem_fwd_rd),
    .mem_fwd_data      (mem_fwd_data),
    .wb_fwd_rd         (wb_fwd_rd),
    .wb_fwd_data       (wb_fwd_data),
    .pc_src            (pc_src),
    .pc_branch_dest    (pc_branch_dest),
    .ex_mem_valid      (ex_mem_valid),
    .ex_mem_ctrl       (ex_mem_ctrl),
    .ex_mem_alu_result (ex_mem_alu_result),
    .ex_mem_write_data (ex_mem_write_data),
    .ex_mem_rd         (ex_mem_rd),
    .ex_mem_pc_plus_4  (ex_mem_pc_plus_4)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Builds a control bundle from its individual fields.
  function automatic ex_ctrl_t mkCtrl(input logic rw, input logic [1:0] rs,
                                      input logic mw, input logic jmp,
                                      input logic jr, input logic br,
                                      input logic [2:0] f3,
                                      input logic [3:0] op,
                                      input logic src);
    ex_ctrl_t c;
    c.regwrite    = rw;
    c.result_src  = rs;
    c.memwrite    = mw;
    c.jump        = jmp;
    c.jalr        = jr;
    c.branch      = br;
    c.funct3      = f3;
    c.alu_control = op;
    c.alu_src     = src;
    return c;
  endfunction

  // Drives one ID/EX slot; register indices are fixed at rs1=1, rs2=2, rd=3.
  task automatic applyStimulus(input logic valid, input ex_ctrl_t ctrl,
                               input logic [31:0] pc, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] imm);
    id_valid     = valid;
    id_ctrl      = ctrl;
    id_pc        = pc;
    id_pc_plus_4 = pc + 32'd4;
    id_rs1_data  = a;
    id_rs2_data  = b;
    id_imm       = imm;
    id_rs1       = 5'd1;
    id_rs2       = 5'd2;
    id_rd        = 5'd3;
  endtask

  // One comparison point: counts it and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  ex_ctrl_t    cAdd;
  ex_ctrl_t    cAddJump;
  ex_ctrl_t    cJalr;
  ex_ctrl_t    cJal;
  ex_ctrl_t    cIdle;
  logic [31:0] fwdExp;

  logic [3:0]  aluOp  [13] = '{4'd1, 4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                               4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd15};
  logic [31:0] aluA   [13] = '{32'h0, 32'hFFFFFFFF, 32'hF0F0, 32'hF000,
                               32'hFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,
                               32'h80000000, 32'h80000000, 32'h5, 32'h5,
                               32'h5};
  logic [31:0] aluB   [13] = '{32'h1, 32'h2, 32'h0FF0, 32'h000F, 32'h0F,
                               32'h1, 32'h1, 32'd35, 32'd4, 32'd33,
                               32'h1234, 32'h6, 32'h6};
  logic [31:0] aluExp [13] = '{32'hFFFFFFFF, 32'h1, 32'h00F0, 32'hF00F,
                               32'hF0, 32'h1, 32'h0, 32'h8, 32'h08000000,
                               32'hC0000000, 32'h1234, 32'h0, 32'h0};

  logic [2:0]  brF3   [11] = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b100,
                               3'b101, 3'b101, 3'b110, 3'b111, 3'b010,
                               3'b011};
  logic [31:0] brA    [11] = '{32'd3, 32'd3, 32'd3, 32'd3, 32'hFFFFFFFF,
                               32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF,
                               32'hFFFFFFFF, 32'd3, 32'd3};
  logic [31:0] brB    [11] = '{32'd3, 32'd4, 32'd4, 32'd3, 32'd1, 32'd1,
                               32'd1, 32'd1, 32'd1, 32'd3, 32'd4};
  logic        brExp  [11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                               1'b0, 1'b1, 1'b0, 1'b0};

  // Linear sequence of directed steps.
  initial begin
    cAdd     = mkCtrl(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 4'd0, 1'b1);
    cAddJump = mkCtrl(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 4'd0, 1'b1);
    cJalr    = mkCtrl(1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 4'd0, 1'b1);
    cJal     = mkCtrl(1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 4'd0, 1'b1);
    cIdle    = '0;

    reset        = 1'b1;
    stall        = 1'b0;
    mem_fwd_rd   = 5'd0;
    mem_fwd_data = 32'd0;
    wb_fwd_rd    = 5'd0;
    wb_fwd_data  = 32'd0;
    applyStimulus(1'b1, cAdd, 32'h0, 32'd5, 32'd0, 32'd7);

    $display("[TB] reset state");
    stepEdge();
    checkOutput("rst_valid", 32'(ex_mem_valid), 32'd0);
    checkOutput("rst_ctrl", 32'(ex_mem_ctrl), 32'd0);
    checkOutput("rst_alu", ex_mem_alu_result, 32'd0);
    checkOutput("rst_rd", 32'(ex_mem_rd), 32'd0);

    $display("[TB] ADD 5+7");
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("add_pcsrc", 32'(pc_src), 32'd0);
    stepEdge();
    checkOutput("add_alu", ex_mem_alu_result, 32'd12);
    checkOutput("add_valid", 32'(ex_mem_valid), 32'd1);
    checkOutput("add_ctrl", 32'(ex_mem_ctrl), 32'h8);
    checkOutput("add_rd", 32'(ex_mem_rd), 32'd3);

    $display("[TB] stall hold");
    @(negedge clk);
    stall = 1'b1;
    applyStimulus(1'b1, cAddJump, 32'h0, 32'd100, 32'd0, 32'd1);
    #1;
    checkOutput("stall_pcsrc", 32'(pc_src), 32'd0);
    for (int i = 0; i < 3; i++) begin
      stepEdge();
      checkOutput("stall_alu", ex_mem_alu_result, 32'd12);
      checkOutput("stall_valid", 32'(ex_mem_valid), 32'd1);
    end
    @(negedge clk);
    stall = 1'b0;

    $display("[TB] ALU table");
    for (int i = 0; i < 13; i++) begin
      applyStimulus(1'b1,
                    mkCtrl(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000,
                           aluOp[i], 1'b0),
                    32'h0, aluA[i], aluB[i], 32'd0);
      stepEdge();
      checkOutput($sformatf("alu_op%0d", aluOp[i]), ex_mem_alu_result,
                  aluExp[i]);
      checkOutput("alu_wdata", ex_mem_write_data, aluB[i]);
      @(negedge clk);
    end

    $display("[TB] branch conditions");
    for (int i = 0; i < 11; i++) begin
      applyStimulus(1'b1,
                    mkCtrl(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, brF3[i],
                           4'd1, 1'b0),
                    32'h100, brA[i], brB[i], 32'h20);
      #1;
      checkOutput($sformatf("br_f3_%0d_%0d", brF3[i], i), 32'(pc_src),
                  32'(brExp[i]));
      applyStimulus(1'b0, cIdle, 32'h0, 32'd0, 32'd0, 32'd0);
      @(negedge clk);
    end
    stall = 1'b1;
    applyStimulus(1'b1, cAddJump, 32'h0, 32'd0, 32'd0, 32'd0);
    #1;
    checkOutput("jump_stalled", 32'(pc_src), 32'd0);
    stall = 1'b0;
    applyStimulus(1'b0, cAddJump, 32'h0, 32'd0, 32'd0, 32'd0);
    #1;
    checkOutput("jump_invalid", 32'(pc_src), 32'd0);
    stepEdge();
    checkOutput("idle_valid", 32'(ex_mem_valid), 32'd0);
    checkOutput("idle_ctrl", 32'(ex_mem_ctrl), 32'd0);

    $display("[TB] BEQ redirect and squash");
    @(negedge clk);
    applyStimulus(1'b1,
                  mkCtrl(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 4'd1,
                         1'b0),
                  32'h100, 32'd3, 32'd3, 32'h20);
    #1;
    checkOutput("beq_pcsrc", 32'(pc_src), 32'd1);
    checkOutput("beq_dest", pc_branch_dest, 32'h120);
    stepEdge();
    checkOutput("beq_valid", 32'(ex_mem_valid), 32'd1);
    @(negedge clk);
    applyStimulus(1'b1, cAddJump, 32'h0, 32'd5, 32'd0, 32'd7);
    for (int i = 0; i < 2; i++) begin
      #1;
      checkOutput("sq_pcsrc", 32'(pc_src), 32'd0);
      stepEdge();
      checkOutput("sq_valid", 32'(ex_mem_valid), 32'd0);
      checkOutput("sq_ctrl", 32'(ex_mem_ctrl), 32'd0);
      @(negedge clk);
    end
    applyStimulus(1'b1, cAdd, 32'h0, 32'd5, 32'd0, 32'd7);
    stepEdge();
    checkOutput("post_sq_valid", 32'(ex_mem_valid), 32'd1);
    checkOutput("post_sq_alu", ex_mem_alu_result, 32'd12);

    $display("[TB] JALR with stall during squash");
    @(negedge clk);
    applyStimulus(1'b1, cJalr, 32'h400, 32'h203, 32'd0, 32'd0);
    #1;
    checkOutput("jalr_pcsrc", 32'(pc_src), 32'd1);
    checkOutput("jalr_dest", pc_branch_dest, 32'h202);
    stepEdge();
    checkOutput("jalr_pc4", ex_mem_pc_plus_4, 32'h404);
    checkOutput("jalr_ctrl", 32'(ex_mem_ctrl), 32'hC);
    checkOutput("jalr_valid", 32'(ex_mem_valid), 32'd1);
    @(negedge clk);
    stall = 1'b1;
    applyStimulus(1'b1, cAdd, 32'h0, 32'd5, 32'd0, 32'd7);
    for (int i = 0; i < 3; i++) begin
      stepEdge();
      checkOutput("jstall_valid", 32'(ex_mem_valid), 32'd1);
      checkOutput("jstall_pc4", ex_mem_pc_plus_4, 32'h404);
    end
    @(negedge clk);
    stall = 1'b0;
    for (int i = 0; i < 2; i++) begin
      stepEdge();
      checkOutput("jsq_valid", 32'(ex_mem_valid), 32'd0);
    end
    stepEdge();
    checkOutput("jsq_done_valid", 32'(ex_mem_valid), 32'd1);

    $display("[TB] forwarding");
    @(negedge clk);
    applyStimulus(1'b1, cAdd, 32'h0, 32'd20, 32'h66, 32'd1);
    mem_fwd_rd   = 5'd1;
    mem_fwd_data = 32'd9;
    wb_fwd_rd    = 5'd1;
    wb_fwd_data  = 32'd4;
`ifdef EX_FORWARD_EN
    fwdExp = 32'd10;
`else
    fwdExp = 32'd21;
`endif
    stepEdge();
    checkOutput("fwd_mem_prio", ex_mem_alu_result, fwdExp);
    @(negedge clk);
    mem_fwd_rd = 5'd4;
`ifdef EX_FORWARD_EN
    fwdExp = 32'd5;
`else
    fwdExp = 32'd21;
`endif
    stepEdge();
    checkOutput("fwd_wb", ex_mem_alu_result, fwdExp);
    @(negedge clk);
    mem_fwd_rd   = 5'd2;
    mem_fwd_data = 32'h55;
    wb_fwd_rd    = 5'd4;
`ifdef EX_FORWARD_EN
    fwdExp = 32'h55;
`else
    fwdExp = 32'h66;
`endif
    stepEdge();
    checkOutput("fwd_none_rs1", ex_mem_alu_result, 32'd21);
    checkOutput("fwd_store", ex_mem_write_data, fwdExp);
    @(negedge clk);
    mem_fwd_rd = 5'd0;
    wb_fwd_rd  = 5'd0;

    $display("[TB] reset during squash");
    applyStimulus(1'b1, cJal, 32'h300, 32'd0, 32'd0, 32'h10);
    #1;
    checkOutput("jal_dest", pc_branch_dest, 32'h310);
    stepEdge();
    checkOutput("jal_valid", 32'(ex_mem_valid), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("arst_valid", 32'(ex_mem_valid), 32'd0);
    checkOutput("arst_ctrl", 32'(ex_mem_ctrl), 32'd0);
    checkOutput("arst_pc4", ex_mem_pc_plus_4, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b1, cAdd, 32'h0, 32'd5, 32'd0, 32'd7);
    stepEdge();
    checkOutput("post_rst_valid", 32'(ex_mem_valid), 32'd1);
    checkOutput("post_rst_alu", ex_mem_alu_result, 32'd12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
